sparse_vector_encoder: RTL and testbench
========================================

# sparse_vector_encoder

Compresses a dense vector of `LANES` unsigned `DW`-bit elements into a serial stream of (value, index) beats, one per non-zero element, ascending lane order. It is the producing end of the sparse operand path: upstream logic delivers dense vectors, and the downstream sparse dot-product datapath consumes only non-zero elements with their lane indices. It uses valid/ready on both sides and supports back-to-back vectors with no bubble.

## Interface
Parameters:
- `LANES`, 16, elements per dense vector (power of two).
- `DW`, 8, element width in bits.
- `IW`, `$clog2(LANES)` = 4, index width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  dense vector offered.
- `in_ready`  out  1  encoder accepts `in_vec` this cycle.
- `in_vec`  in  LANES*DW  dense vector; lane i = `in_vec[i*DW +: DW]`, lane 0 at LSBs.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_value`  out  DW  non-zero element value; 0 only on an all-zero beat.
- `out_index`  out  IW  lane index of `out_value`.
- `out_last`  out  1  final beat of current vector.
- `out_zero`  out  1  vector had no non-zero lanes; single-beat vector.

## Operation
- State machine, two states:
  - IDLE: no vector held.
  - EMIT: vector held, beats pending.
- Input handshake: a transfer occurs when `in_valid && in_ready`.
  - `in_ready = (state==IDLE) || (out_valid && out_ready && out_last)`.
- On accept:
  - Latch the vector.
  - Build `mask[i] = (lane i != 0)`.
  - Go to EMIT.
- EMIT with mask != 0:
  - Present the lowest set lane p: `out_value` = lane p, `out_index` = p.
  - `out_last` = 1 when mask has exactly one bit set.
  - `out_zero` = 0.
- EMIT with mask == 0:
  - Present one beat: `out_value`=0, `out_index`=0, `out_last`=1, `out_zero`=1.
- On `out_valid && out_ready`:
  - Clear bit p.
  - If the beat was last:
    - Go to IDLE, or
    - if a new vector is accepted in the same cycle, stay in EMIT with the new mask.
- Stall: while `out_valid && !out_ready`, all out_* hold stable.
  - `in_vec` changes have no effect after accept.
- A non-zero test is an exact compare with 0; values are unsigned and pass through unmodified.

## Timing
- Reset (asynchronous assert; release synchronous to `clk`):
  - State IDLE, mask 0.
  - `out_valid`, `out_value`, `out_index`, `out_last`, `out_zero` = 0.
  - `in_ready` = 1 after reset.
- Latency:
  - Vector accepted at edge N → first beat has `out_valid`=1 after edge N (registered outputs).
  - One beat per cycle while `out_ready`=1.
  - A k-non-zero vector occupies max(k,1) output cycles.
- Back-to-back: the last-beat handshake and new vector accept at the same edge → next vector's first beat appears with no idle cycle.
- Reset mid-vector: pending beats are discarded; no partial beat appears after reset.
- `in_valid` while busy and not on a last-beat handshake: `in_ready`=0 and the vector is not consumed.

## Configuration
- `SPARSE_ENC_STATS_EN` defined adds output ports:
  - `stat_vectors` [15:0]: counts completed vectors (last-beat handshakes).
  - `stat_nnz` [23:0]: counts non-zero beats emitted; zero beats are excluded.
  - Both reset to 0 and wrap modulo 2^width.
- Undefined: ports and counters absent; all other behaviour is identical.

## Structure
- Package `sparse_pkg` holds:
  - `SPARSE_LANES`, `SPARSE_DW`, `SPARSE_IW` constants.
  - State enum `enc_state_t` {IDLE, EMIT}.
  - Beat struct {value, index, last, zero}, shared with the sparse dot-product consumer.
- One sub-module, `lane_pick`: combinational lowest-set-bit priority encoder.
  - Input `mask[LANES]`.
  - Outputs `idx[IW]`, `any`, `one_hot_only` (exactly one bit set).

## Test plan
- Reset, then vector with lane3=0x05, lane10=0xFF, others 0, `out_ready`=1 → beats (0x05,3,last0), (0xFF,10,last1) on consecutive cycles; `in_ready`=1 on the second.
- All-zero vector → single beat value 0, index 0, `out_last`=1, `out_zero`=1.
- All lanes 0xFF → 16 beats, indices 0..15, value 0xFF, `out_last` only on index 15; with stats enabled, `stat_nnz`=16, `stat_vectors`=1.
- Two vectors offered back-to-back with `in_valid` held → second vector's first beat follows the first vector's last beat with no gap.
- `out_ready` toggled 1,0,0,1 during lane1=0x11, lane2=0x22 → outputs stable while low; exactly two beats delivered; new `in_vec` presented mid-vector is not accepted.
- `rst` asserted after first beat of a 3-non-zero vector → `out_valid`=0 immediately; after release, `in_ready`=1 and no remaining beats appear.

Source files
------------

// File: rtl/sparse_pkg.sv
// sparse_pkg: shared constants, encoder state and beat format for the sparse operand path.
package sparse_pkg;
  localparam int SPARSE_LANES = 16;
  localparam int SPARSE_DW = 8;
  localparam int SPARSE_IW = $clog2(SPARSE_LANES);
  typedef enum logic {IDLE, EMIT} enc_state_t;
  typedef struct packed {
    logic [SPARSE_DW-1:0] value;
    logic [SPARSE_IW-1:0] index;
    logic                 last;
    logic                 zero;
  } beat_t;
endpackage

// File: rtl/sparse_vector_encoder_lane_pick.sv
// lane_pick: lowest-set-bit priority encoder with any / exactly-one flags.
module lane_pick
  import sparse_pkg::*;
#(
  parameter int LANES = SPARSE_LANES,
  localparam int IW = $clog2(LANES)
) (
  input  logic [LANES-1:0] mask,
  output logic [IW-1:0]    idx,
  output logic             any,
  output logic             one_hot_only
);
  always_comb begin
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--) if (mask[i]) idx = IW'(i);
  end
  assign any = |mask;
  assign one_hot_only = any && ((mask & (mask - LANES'(1))) == '0);
endmodule

// File: rtl/sparse_vector_encoder.sv
// sparse_vector_encoder: dense vector to (value, index) beat stream, non-zero lanes in ascending order.
// Optional SPARSE_ENC_STATS_EN adds stat_vectors / stat_nnz counters.
module sparse_vector_encoder
  import sparse_pkg::*;
#(
  parameter int LANES = SPARSE_LANES,
  parameter int DW = SPARSE_DW,
  localparam int IW = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_value,
  output logic [IW-1:0]       out_index,
  output logic                out_last,
  output logic                out_zero
`ifdef SPARSE_ENC_STATS_EN
  ,
  output logic [15:0]         stat_vectors,
  output logic [23:0]         stat_nnz
`endif
);
  enc_state_t          state_q, state_d;
  logic [LANES*DW-1:0] vec_q, vec_d;
  logic [LANES-1:0]    mask_q, mask_d, in_mask;
  logic [IW-1:0]       pick;
  logic                any, one, emit, fire, fin, accept;

  lane_pick #(.LANES(LANES)) u_pick (
    .mask(mask_q),
    .idx(pick),
    .any(any),
    .one_hot_only(one)
  );

  always_comb begin
    for (int i = 0; i < LANES; i++) in_mask[i] = in_vec[i*DW +: DW] != '0;
  end

  // Outputs come straight from held state, so they are stable under backpressure.
  assign emit = state_q == EMIT;
  assign out_valid = emit;
  assign out_value = emit ? vec_q[pick*DW +: DW] : '0;
  assign out_index = emit ? pick : '0;
  assign out_last = emit && (one || !any);
  assign out_zero = emit && !any;
  assign fire = out_valid && out_ready;
  assign fin = fire && out_last;
  assign in_ready = !emit || fin;
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    mask_d = mask_q;
    if (accept) begin
      state_d = EMIT;
      vec_d = in_vec;
      mask_d = in_mask;
    end else if (fin) begin
      state_d = IDLE;
      mask_d = '0;
    end else if (fire) begin
      mask_d = mask_q & ~(LANES'(1) << pick);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      mask_q <= mask_d;
    end
  end

`ifdef SPARSE_ENC_STATS_EN
  logic [15:0] vec_cnt_q;
  logic [23:0] nnz_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_cnt_q <= '0;
      nnz_cnt_q <= '0;
    end else begin
      if (fin) vec_cnt_q <= vec_cnt_q + 16'd1;
      if (fire && !out_zero) nnz_cnt_q <= nnz_cnt_q + 24'd1;
    end
  end
  assign stat_vectors = vec_cnt_q;
  assign stat_nnz = nnz_cnt_q;
`endif
endmodule

// File: tb/tb_sparse_vector_encoder.sv
// tb_sparse_vector_encoder: directed stimulus with a queue scoreboard and an independent beat monitor.
module tb_sparse_vector_encoder;
  logic         clk = 0;
  logic         rst = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [127:0] in_vec = '0;
  logic         out_valid;
  logic         out_ready = 1;
  logic [7:0]   out_value;
  logic [3:0]   out_index;
  logic         out_last;
  logic         out_zero;
`ifdef SPARSE_ENC_STATS_EN
  logic [15:0]  stat_vectors;
  logic [23:0]  stat_nnz;
`endif

  sparse_vector_encoder dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_vec(in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_index(out_index),
    .out_last(out_last),
    .out_zero(out_zero)
`ifdef SPARSE_ENC_STATS_EN
    ,
    .stat_vectors(stat_vectors),
    .stat_nnz(stat_nnz)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  logic [13:0] exp_q[$];
  logic        stall_q = 0;
  logic [14:0] snap;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_beat(input logic [7:0] v, input logic [3:0] i, input logic l, input logic z);
    exp_q.push_back({v, i, l, z});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (stall_q) chk("stall_hold", {out_valid, out_value, out_index, out_last, out_zero}, snap);
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got %0h/%0d last %0b zero %0b expected none", out_value, out_index, out_last, out_zero);
        end else begin
          chk("beat", {out_value, out_index, out_last, out_zero}, exp_q.pop_front());
        end
      end
      stall_q = out_valid && !out_ready;
      snap = {out_valid, out_value, out_index, out_last, out_zero};
    end else stall_q = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] v);
    int n = 0;
    in_vec = v;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready 0 expected 1");
    end
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic clear_stats();
    beat_cnt = 0;
    first_cyc = -1;
    last_cyc = -1;
  endtask

  task automatic pulse_reset();
    rst = 0;
    exp_q.delete();
    tick();
    tick();
    rst = 1;
    tick();
  endtask

  initial begin
    logic [127:0] v;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_value, out_index, out_last, out_zero}, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef SPARSE_ENC_STATS_EN
    chk("rst_stats", {stat_vectors, stat_nnz}, 0);
`endif
    rst = 1;
    tick();

    clear_stats();
    v = '0;
    v[3*8 +: 8] = 8'h05;
    v[10*8 +: 8] = 8'hFF;
    expect_beat(8'h05, 4'd3, 0, 0);
    expect_beat(8'hFF, 4'd10, 1, 0);
    send(v);
    @(negedge clk);
    chk("t1_in_ready_first", in_ready, 0);
    @(negedge clk);
    chk("t1_in_ready_last", in_ready, 1);
    drain();
    chk("t1_consecutive", last_cyc - first_cyc, 1);

    expect_beat(8'h00, 4'd0, 1, 1);
    send('0);
    drain();

    pulse_reset();
    clear_stats();
    for (int i = 0; i < 16; i++) expect_beat(8'hFF, 4'(i), i == 15, 0);
    send({16{8'hFF}});
    drain();
    chk("ff_beats", beat_cnt, 16);
    chk("ff_span", last_cyc - first_cyc, 15);
`ifdef SPARSE_ENC_STATS_EN
    chk("ff_stat_nnz", stat_nnz, 16);
    chk("ff_stat_vectors", stat_vectors, 1);
`endif

    clear_stats();
    v = '0;
    v[0 +: 8] = 8'h01;
    v[7*8 +: 8] = 8'h07;
    expect_beat(8'h01, 4'd0, 0, 0);
    expect_beat(8'h07, 4'd7, 1, 0);
    send(v);
    v = '0;
    v[15*8 +: 8] = 8'h0F;
    v[2*8 +: 8] = 8'h20;
    expect_beat(8'h20, 4'd2, 0, 0);
    expect_beat(8'h0F, 4'd15, 1, 0);
    send(v);
    drain();
    chk("b2b_beats", beat_cnt, 4);
    chk("b2b_no_gap", last_cyc - first_cyc, 3);

    clear_stats();
    v = '0;
    v[1*8 +: 8] = 8'h11;
    v[2*8 +: 8] = 8'h22;
    expect_beat(8'h11, 4'd1, 0, 0);
    expect_beat(8'h22, 4'd2, 1, 0);
    send(v);
    tick();
    out_ready = 0;
    v = '0;
    v[0 +: 8] = 8'h99;
    in_vec = v;
    in_valid = 1;
    @(negedge clk);
    chk("stall_in_ready_a", in_ready, 0);
    chk("stall_valid", {out_valid, out_value, out_index}, {1'b1, 8'h22, 4'd2});
    tick();
    @(negedge clk);
    chk("stall_in_ready_b", in_ready, 0);
    tick();
    out_ready = 1;
    in_valid = 0;
    drain();
    repeat (4) tick();
    chk("stall_beats", beat_cnt, 2);
    chk("stall_idle", out_valid, 0);

    clear_stats();
    v = '0;
    v[0 +: 8] = 8'h0A;
    v[4*8 +: 8] = 8'h0B;
    v[9*8 +: 8] = 8'h0C;
    expect_beat(8'h0A, 4'd0, 0, 0);
    expect_beat(8'h0B, 4'd4, 0, 0);
    expect_beat(8'h0C, 4'd9, 1, 0);
    send(v);
    tick();
    rst = 0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outputs", {out_value, out_index, out_last, out_zero}, 0);
    chk("midrst_beats_before", beat_cnt, 1);
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    repeat (5) tick();
    chk("midrst_no_residue", beat_cnt, 1);
    chk("midrst_idle", out_valid, 0);
`ifdef SPARSE_ENC_STATS_EN
    chk("midrst_stats", {stat_vectors, stat_nnz}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
